// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then shifts one
// command byte (LSB first, odd parity, stop) on device clock falls and checks the device ack.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 500,
  parameter int unsigned TIMEOUT_CYCLES = 75000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StInhibit  = 3'd1;
  localparam logic [2:0] StReq      = 3'd2;
  localparam logic [2:0] StShift    = 3'd3;
  localparam logic [2:0] StAck      = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [9:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            line_q, line_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  logic fall;
  logic tmo_active;
  logic tmo_hit;
  logic done_d;
  logic error_d;

  // Two-flop synchronisers, preset to the idle-high bus level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  assign tmo_active = (state_q == StReq) || (state_q == StShift) ||
                      (state_q == StAck) || (state_q == StWaitIdle);
  assign tmo_hit    = tmo_active && (tmo_cnt_q == TmoLast);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    line_d    = line_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      StIdle: begin
        inh_cnt_d = '0;
        tmo_cnt_d = '0;
        bit_cnt_d = '0;
        line_d    = 1'b0;
        if (tx_valid) begin
          // Frame as shifted out after the start bit: data LSB first, odd parity, stop.
          shift_d = {1'b1, ~^tx_data, tx_data};
          state_d = StInhibit;
        end
      end

      StInhibit: begin
        if (inh_cnt_q == InhLast) begin
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = StReq;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      StReq, StShift, StAck, StWaitIdle: begin
        if (tmo_hit) begin
          // Timeout wins over a fall seen in the same cycle.
          error_d = 1'b1;
          line_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = fall ? '0 : tmo_cnt_q + 1'b1;
          case (state_q)
            StReq: begin
              if (fall) begin
                line_d    = ~shift_q[0];
                shift_d   = {1'b0, shift_q[9:1]};
                bit_cnt_d = 4'd1;
                state_d   = StShift;
              end
            end
            StShift: begin
              if (fall) begin
                line_d    = ~shift_q[0];
                shift_d   = {1'b0, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'd9) begin
                  state_d = StAck;
                end
              end
            end
            StAck: begin
              if (fall) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (!dat_s2_q) begin
                  state_d = StWaitIdle;
                end else begin
                  error_d = 1'b1;
                  state_d = StIdle;
                end
              end
            end
            default: begin
              if (clk_s2_q && dat_s2_q) begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end
          endcase
        end
      end

      default: begin
        line_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      line_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      line_q    <= line_d;
    end
  end

  assign tx_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign tx_done  = done_d;
  assign tx_error = error_d;

  // Line drivers decode straight from state so reset releases them with no clock.
  assign ps2_clk_oe  = (state_q == StInhibit);
  assign ps2_data_oe = ((state_q == StInhibit) && (inh_cnt_q == InhLast)) ||
                       ((state_q == StReq) && !tmo_hit) ||
                       ((state_q == StShift) && line_q && !tmo_hit);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the DUT; expected
// outcomes and line bits are queued at issue time and checked by an independent pulse monitor.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic clk_line, data_line;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  always #100 clk = ~clk;   // 5 MHz

  ps2_host_tx dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  typedef struct {
    bit          err;
    bit          chk;
    logic [10:0] bits;   // {stop, parity, d7..d0, start}
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_bits = '0;
  longint      cyc = 0;
  longint      fall_cyc = 0;
  longint      err_cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;
  int          inh_run = 0;
  int          inh_first = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!reset && tx_valid && tx_ready) n_acc <= n_acc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Outcome monitor: pops one expectation per done/error pulse.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && (tx_done || tx_error)) begin
        check("pulse_excl", 32'(tx_done & tx_error), 32'd0);
        check("busy_ready_at_pulse", {30'd0, busy, tx_ready}, 32'b10);
        check("oe_at_pulse", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        if (tx_error) err_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got done=%0b error=%0b want none", tx_done, tx_error);
        end else begin
          mon_e = exp_q.pop_front();
          check("outcome_is_error", 32'(tx_error), 32'(mon_e.err));
          if (mon_e.chk) check("line_bits", 32'(obs_bits), 32'(mon_e.bits));
        end
        @(negedge clk);
        check("idle_after_pulse",
              {26'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}, 32'b100000);
      end
    end
  end

  // Inhibit monitor: length of each clk_oe run and the cycle the start bit appears in it.
  initial begin : inh_mon
    forever begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        inh_run++;
        if (ps2_data_oe && inh_first == 0) inh_first = inh_run;
      end else if (inh_run != 0) begin
        check("inhibit_len", 32'(inh_run), 32'd500);
        check("start_bit_cycle", 32'(inh_first), 32'd500);
        inh_run   = 0;
        inh_first = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: waits for inhibit and request-to-send, then clocks nfall falls; samples each
  // bit while its clock is high and optionally pulls data low across fall 11 as the ack.
  task automatic device_frame(input int half, input int nfall, input bit ack);
    int n;
    n = 0;
    while (clk_line !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (clk_line !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL dev_inhibit_wait: got clk line %0b want 0", clk_line);
      return;
    end
    n = 0;
    while (clk_line !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (clk_line !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL dev_rts_wait: got clk line %0b want 1", clk_line);
      return;
    end
    obs_bits[0] = data_line;
    repeat (half) @(negedge clk);
    for (int k = 1; k <= nfall; k++) begin
      if (k == 11 && ack) begin
        dev_data = 1'b0;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (k == nfall) fall_cyc = cyc;
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
      repeat (half / 2) @(negedge clk);
      if (k <= 10) obs_bits[k] = data_line;
      repeat (half - half / 2) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL outcome_wait: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  int acc0;

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_error", {30'd0, tx_done, tx_error}, 32'd0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED at a 60 us device clock period: parity 1.
    exp_q.push_back('{err: 1'b0, chk: 1'b1, bits: 11'b1_1_11101101_0});
    issue(8'hED);
    device_frame(150, 11, 1'b1);
    drain(200);

    exp_q.push_back('{err: 1'b0, chk: 1'b1, bits: 11'b1_0_00000111_0});
    issue(8'h07);
    device_frame(30, 11, 1'b1);
    drain(200);

    exp_q.push_back('{err: 1'b0, chk: 1'b1, bits: 11'b1_1_00000000_0});
    issue(8'h00);
    device_frame(30, 11, 1'b1);
    drain(200);

    // No acknowledge: data stays high on fall 11.
    exp_q.push_back('{err: 1'b1, chk: 1'b1, bits: 11'b1_1_00111100_0});
    issue(8'h3C);
    device_frame(30, 11, 1'b0);
    drain(200);

    // Device stalls after fall 4; error lands 2 sync cycles + 75000 cycles after the line falls.
    err_cyc = 0;
    exp_q.push_back('{err: 1'b1, chk: 1'b0, bits: 11'd0});
    issue(8'h12);
    device_frame(30, 4, 1'b1);
    drain(80000);
    check("timeout_cycles", 32'(err_cyc - fall_cyc), 32'd75002);

    // Reset mid-SHIFT after fall 6 of 0x00: bit 5 is 0, so data is being pulled low.
    issue(8'h00);
    device_frame(30, 6, 1'b1);
    check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #30;
    reset = 1'b1;
    #1;
    check("reset_oe_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("reset_ready_busy", {30'd0, tx_ready, busy}, 32'b10);
    check("reset_no_pulse", {30'd0, tx_done, tx_error}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    exp_q.push_back('{err: 1'b0, chk: 1'b1, bits: 11'b1_1_11111111_0});
    issue(8'hFF);
    device_frame(30, 11, 1'b1);
    drain(200);

    // tx_valid held high across two 0x55 frames.
    acc0 = n_acc;
    exp_q.push_back('{err: 1'b0, chk: 1'b1, bits: 11'b1_1_01010101_0});
    exp_q.push_back('{err: 1'b0, chk: 1'b1, bits: 11'b1_1_01010101_0});
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    device_frame(30, 11, 1'b1);
    check("held_valid_mid_frame_acc", 32'(n_acc - acc0), 32'd1);
    device_frame(30, 11, 1'b1);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    tx_valid = 1'b0;
    drain(10);
    check("held_valid_total_acc", 32'(n_acc - acc0), 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) followed by an LED mask, or 0xFF (reset).
- It is the write direction of the PS/2 link; the keyboard block is the read direction.
- It drives the shared open-drain ps2 clock and data lines through low-active output enables.
- It raises busy so the receive path ignores the bus while a frame is being sent.

Parameters:
- INHIBIT_CYCLES, 500: number of clk cycles the host holds ps2 clock low before the start bit (100 us at 5 MHz).
- TIMEOUT_CYCLES, 75000: maximum number of clk cycles between device clock falling edges, and also the limit for the wait-for-idle phase (15 ms at 5 MHz).

Ports:
- clk  in  1  system clock (5 MHz).
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  send request; accepted only when tx_ready=1.
- tx_ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: device acknowledged the byte and the bus has returned to idle.
- tx_error  out  1  one-cycle pulse: no acknowledge received, or timeout.
- ps2_clk_in  in  1  raw ps2 clock line, asynchronous.
- ps2_data_in  in  1  raw ps2 data line, asynchronous.
- ps2_clk_oe  out  1  1 = pull the ps2 clock line low; 0 = release it.
- ps2_data_oe  out  1  1 = pull the ps2 data line low; 0 = release it.

Behaviour:
- Clock and reset: single clock domain on clk. Reset is asynchronous and active-high.
- Reset values: all outputs 0 except tx_ready=1. State = IDLE, all counters 0, both synchronisers preset to 1. The lines are released immediately on reset assertion, mid-frame included.
- Input synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser. A falling edge (fall) is the synchronised clock changing from 1 to 0; it is detected one cycle after the second flop.
- Acceptance: when tx_valid=1 in IDLE, latch tx_data and parity = ~^tx_data (odd parity), then move to INHIBIT on the next cycle. tx_valid is ignored in every other state.
- INHIBIT state:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe rises on the last of those cycles (start bit, data=0).
  - Next state is REQ.
- REQ state:
  - ps2_clk_oe=0, ps2_data_oe=1. The start bit is now on the line for the device to sample.
  - Bit counter = 0. Timeout counter cleared.
- SHIFT state (entered on the first fall):
  - On each fall, the counter increments and the host updates data the same cycle the fall is detected.
  - Fall 1..8: data bit 0..7, LSB first.
  - Fall 9: parity bit.
  - Fall 10: stop bit (ps2_data_oe=0). Move to ACK.
  - Data encoding: ps2_data_oe = ~bit, so a 0 bit pulls the line low.
- ACK state:
  - On fall 11, sample synchronised data.
  - Data = 0: move to WAIT_IDLE.
  - Data = 1: pulse tx_error and go to IDLE.
- WAIT_IDLE state:
  - Wait until synchronised clock=1 and data=1 for 1 cycle.
  - Then pulse tx_done and go to IDLE.
- Timeout:
  - In REQ, SHIFT, ACK and WAIT_IDLE, a counter increments every cycle and clears on each fall.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE. Timeout takes priority over a fall detected in the same cycle.
- Exclusivity: tx_done and tx_error are never high in the same cycle. tx_ready is 0 for the cycle in which either pulse is high; IDLE is entered on the following cycle.
- Counter widths:
  - Bit counter: 4 bits.
  - Inhibit and timeout counters: each sized by $clog2 of its parameter plus 1; neither may wrap.
- Safety invariant: ps2_clk_oe and ps2_data_oe are never asserted outside INHIBIT, REQ and SHIFT.

Test Plan:
- Send 0xED with a device model clocking at a 60 us period and acking. Required:
  - clk_oe low for exactly 500 cycles.
  - Line bits start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Ack accepted, then one tx_done pulse, tx_error never high.
- Send 0x07 (parity 0) and 0x00 (parity 1). Required: parity bit on the line matches; each frame ends with tx_done.
- Device model omits the ack (data stays high on fall 11). Required: one tx_error pulse, no tx_done, both oe outputs 0, tx_ready=1 on the next cycle.
- Device model stops clocking after fall 4. Required: tx_error exactly 75000 cycles after fall 4, lines released.
- Assert reset during SHIFT (after fall 6). Required: both oe outputs 0 in the same cycle; tx_ready=1, busy=0, no done/error pulse. A following 0xFF frame completes normally.
- Hold tx_valid=1 continuously while sending 0x55. Required: second byte accepted only after return to IDLE, and each frame begins with a full 500-cycle inhibit.
